ex_mem: RTL
===========

# ex_mem

Pipeline register between the execute stage and the memory-access stage of the five-stage MIPS core. On each clock edge it captures the execute stage's register-file write request (`wd`, `wreg`, `wdata`) and its HI/LO write request (`hi`, `lo`, `whilo`), then presents them to the memory stage. It also holds the multiply-accumulate scratch state (`hilo_temp`, `cnt`) and feeds it back to the execute stage, so two-cycle MADD/MADDU/MSUB/MSUBU operations survive their self-inserted stall. It obeys the global stall vector and the pipeline flush.

## Interface
Parameters: none. Widths are fixed: word 32, register address 5, double word 64.

Ports:
- `clk`  in  1  rising-edge clock
- `rst`  in  1  reset; synchronous, active-high
- `flush`  in  1  pipeline flush (exception/eret); clears the stage
- `stall`  in  6  global stall vector; bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB
- `ex_wd`  in  5  destination GPR from EX
- `ex_wreg`  in  1  GPR write enable from EX
- `ex_wdata`  in  32  GPR write data from EX
- `ex_hi`, `ex_lo`  in  32 each  HI/LO write values from EX
- `ex_whilo`  in  1  HI/LO write enable from EX
- `hilo_i`  in  64  MADD/MSUB partial result from EX (`hilo_temp_o`)
- `cnt_i`  in  2  MADD/MSUB cycle counter from EX (`cnt_o`)
- `mem_wd`  out  5  registered `ex_wd`
- `mem_wreg`  out  1  registered `ex_wreg`
- `mem_wdata`  out  32  registered `ex_wdata`
- `mem_hi`, `mem_lo`  out  32 each  registered `ex_hi`/`ex_lo`
- `mem_whilo`  out  1  registered `ex_whilo`
- `hilo_o`  out  64  partial result fed back to EX `hilo_temp_i`
- `cnt_o`  out  2  counter fed back to EX `cnt_i`

## Operation
- All outputs are registers. Every update happens on the rising edge of `clk`.
- Priority at each edge, highest first: `rst`, `flush`, bubble, pass, hold.
- `rst`=1: every output is set to 0. That is `mem_wd`=0, `mem_wreg`=0, `mem_wdata`=0, `mem_hi`=0, `mem_lo`=0, `mem_whilo`=0, `hilo_o`=0, `cnt_o`=0.
- `flush`=1: every output is cleared to 0, the same as reset. This applies regardless of `stall`, and it discards any in-progress MADD/MSUB partial.
- Bubble (`stall[3]`=1 and `stall[4]`=0): EX is stalled but MEM is not.
  - MEM-side outputs go to 0, so a NOP enters MEM.
  - `hilo_o` ← `hilo_i` and `cnt_o` ← `cnt_i`. This is the only case in which the feedback state is captured.
- Pass (`stall[3]`=0):
  - MEM-side outputs load from their `ex_*` inputs.
  - `hilo_o` ← 0 and `cnt_o` ← 0, so the next multi-cycle op starts from cnt=0.
- Hold (`stall[3]`=1 and `stall[4]`=1): all outputs keep their values, including the feedback state.
- MEM-side data passes through without modification. No width changes, no sign handling, no arithmetic.
- `cnt` values: only 0, 1 and 2 are produced upstream. The value 3 is stored verbatim; it is not treated as an error.

## Timing
- Latency: exactly 1 cycle from `ex_*` to `mem_*` when passing.
- Feedback path: `hilo_i`/`cnt_i` captured at edge N appear on `hilo_o`/`cnt_o` in cycle N+1, when EX re-evaluates the same instruction.
- No combinational path from any input to any output.
- MADD/MSUB sequence:
  - Cycle A: EX presents cnt=1 and the product, and raises its stall request, so `stall`=6'b001111 and the edge performs a bubble.
  - Cycle A+1: `cnt_o`=1. EX produces the accumulated result and drops its stall request. The edge performs a pass, which delivers the result on `mem_hi`/`mem_lo` and resets `cnt_o` to 0.
- Reset mid-sequence (`cnt_o`=1): the next edge forces `cnt_o`=0. The instruction is not replayed by this block.
- Flush arriving together with a bubble request: flush wins, so `cnt_o`=0.
- Hold lasting multiple cycles: outputs stay stable for the whole duration. Releasing to pass resumes without data loss.

## Test plan
1. Reset: drive all inputs nonzero with `rst`=1 for one edge -> every output is 0. Then drive `rst`=0 and `stall`=0 with `ex_wd`=5'd3, `ex_wreg`=1, `ex_wdata`=32'hDEADBEEF -> one edge later `mem_wd`=3, `mem_wreg`=1, `mem_wdata`=32'hDEADBEEF.
2. Bubble: set `stall`=6'b001111, `ex_wreg`=1, `ex_whilo`=1, `hilo_i`=64'h0000_0001_0000_0002, `cnt_i`=1 -> `mem_wreg`=0, `mem_whilo`=0, `mem_wdata`=0, `hilo_o`=64'h0000_0001_0000_0002, `cnt_o`=1.
3. MADD two-cycle sequence:
   - First edge: `stall`=6'b001111, `cnt_i`=1, `hilo_i`=64'd6.
   - Second edge: `stall`=0, `ex_whilo`=1, `ex_hi`=0, `ex_lo`=32'd16.
   - Required: after the first edge `cnt_o`=1 and `hilo_o`=6. After the second edge `mem_whilo`=1, `mem_lo`=16, `cnt_o`=0, `hilo_o`=0.
4. Hold: load `mem_wdata`=32'h1234, then set `stall`=6'b011111 for 3 edges while `ex_wdata` changes every cycle -> `mem_wdata` stays 32'h1234 and `cnt_o`/`hilo_o` are unchanged.
5. Flush with stall: with `cnt_o`=1 and `mem_wreg`=1, assert `flush`=1 together with `stall`=6'b001111 -> after one edge all outputs are 0.
6. Reset over flush and pass: assert `rst`=1, `flush`=0, `stall`=0 with valid `ex_*` -> all outputs 0. Deassert `rst` -> the next edge passes `ex_*` normally.

Source files
------------

// File: rtl/ex_mem.sv
// ex_mem: EX -> MEM pipeline register of the five-stage MIPS core.
// Captures the EX stage's GPR write request (wd/wreg/wdata) and HI/LO write
// request (hi/lo/whilo) and presents them to MEM. Also holds the
// multiply-accumulate scratch state (hilo/cnt) that is fed back to EX so a
// two-cycle MADD/MSUB survives its own stall.
//
// Ports:
//   clk, rst              rising-edge clock, synchronous active-high reset
//   flush                 clears the whole stage (exception/eret)
//   stall[5:0]            global stall vector (bit3 EX, bit4 MEM)
//   ex_wd/wreg/wdata      GPR write request from EX
//   ex_hi/lo/whilo        HI/LO write request from EX
//   hilo_i, cnt_i         MADD/MSUB partial result and counter from EX
//   mem_*                 registered EX request presented to MEM
//   hilo_o, cnt_o         registered partial result / counter back to EX
module ex_mem (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic [5:0]  stall,
    input  logic [4:0]  ex_wd,
    input  logic        ex_wreg,
    input  logic [31:0] ex_wdata,
    input  logic [31:0] ex_hi,
    input  logic [31:0] ex_lo,
    input  logic        ex_whilo,
    input  logic [63:0] hilo_i,
    input  logic [1:0]  cnt_i,
    output logic [4:0]  mem_wd,
    output logic        mem_wreg,
    output logic [31:0] mem_wdata,
    output logic [31:0] mem_hi,
    output logic [31:0] mem_lo,
    output logic        mem_whilo,
    output logic [63:0] hilo_o,
    output logic [1:0]  cnt_o
);

    logic bubble;
    logic pass;

    // EX stalled while MEM runs: inject a NOP into MEM and keep the partial.
    assign bubble = stall[3] & ~stall[4];
    assign pass   = ~stall[3];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            mem_wd    <= 5'd0;
            mem_wreg  <= 1'b0;
            mem_wdata <= 32'd0;
            mem_hi    <= 32'd0;
            mem_lo    <= 32'd0;
            mem_whilo <= 1'b0;
            hilo_o    <= 64'd0;
            cnt_o     <= 2'd0;
        end else if (bubble) begin
            mem_wd    <= 5'd0;
            mem_wreg  <= 1'b0;
            mem_wdata <= 32'd0;
            mem_hi    <= 32'd0;
            mem_lo    <= 32'd0;
            mem_whilo <= 1'b0;
            hilo_o    <= hilo_i;
            cnt_o     <= cnt_i;
        end else if (pass) begin
            mem_wd    <= ex_wd;
            mem_wreg  <= ex_wreg;
            mem_wdata <= ex_wdata;
            mem_hi    <= ex_hi;
            mem_lo    <= ex_lo;
            mem_whilo <= ex_whilo;
            // Next multi-cycle op starts from cnt=0.
            hilo_o    <= 64'd0;
            cnt_o     <= 2'd0;
        end
        // Otherwise hold: EX and MEM both stalled.
    end

endmodule
